// File: rtl/gnw_lcd_pkg.sv
// gnw_lcd_pkg: shared constants, state codes and phase decode
// for the SM510 LCD capture block.
package gnw_lcd_pkg;

  localparam int NUM_COMMONS     = 4;
  localparam int SEGS_PER_COMMON = 32;
  localparam int DISP_BITS       = NUM_COMMONS * SEGS_PER_COMMON;

  typedef logic [1:0] lcd_state_t;

  localparam lcd_state_t SEEK   = 2'd0;
  localparam lcd_state_t RUN    = 2'd1;
  localparam lcd_state_t COMMIT = 2'd2;

  // {valid, idx}: valid only for an exactly one-hot strobe
  function automatic logic [2:0] onehot_idx(
    input logic [NUM_COMMONS-1:0] h
  );
    logic [2:0] r;
    case (h)
      4'b0001: r = 3'b100;
      4'b0010: r = 3'b101;
      4'b0100: r = 3'b110;
      4'b1000: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gnw_lcd_persist.sv
// gnw_lcd_persist: per-segment frame persistence counters.
// A segment stays lit for PERSIST frames after it was last seen on.
import gnw_lcd_pkg::*;

module gnw_lcd_persist #(
  parameter int PERSIST = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit,
  input  logic [DISP_BITS-1:0] seen,
  output logic [DISP_BITS-1:0] lit
);

  localparam int CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] FULL = CW'(PERSIST);

  logic [CW-1:0] cnt [DISP_BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DISP_BITS; i++)
        cnt[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < DISP_BITS; i++) begin
        if (seen[i])
          cnt[i] <= FULL;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < DISP_BITS; i++)
      lit[i] = (cnt[i] != '0);
  end

endmodule

// File: rtl/gnw_lcd_capture.sv
// gnw_lcd_capture: demultiplexes SM510 segment/common outputs into
// a lockable 4x32 display image with persistence and stall detection.
import gnw_lcd_pkg::*;

module gnw_lcd_capture #(
  parameter int PERSIST      = 2,
  parameter int STALL_CYCLES = 8000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] segA,
  input  logic [15:0] segB,
  input  logic [3:0]  H,
  input  logic        Bs,
  input  logic        lock,
  input  logic [6:0]  rd_addr,
  output logic        rd_data,
  output logic        bs_out,
  output logic        frame_done,
  output logic        sync_err,
  output logic        stall
);

  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(STALL_CYCLES);

  logic [3:0]           h_q;
  logic [3:0]           h_prev;
  logic [31:0]          seg_q;
  logic                 bs_q;
  logic [2:0]           oh;
  logic [1:0]           idx;
  logic                 ev;
  logic                 v_ev;
  logic                 bad_ev;
  logic                 ph0;
  lcd_state_t           state_q;
  logic [1:0]           nxt;
  logic [DISP_BITS-1:0] work;
  logic [DISP_BITS-1:0] disp;
  logic [DISP_BITS-1:0] lit;
  logic                 bs_acc;
  logic                 bs_last;
  logic                 pending;
  logic                 commit;
  logic [SW-1:0]        scnt;
  logic                 stall_r;
  logic                 stall_hit;

  assign oh        = onehot_idx(h_q);
  assign idx       = oh[1:0];
  assign ev        = (h_q != h_prev);
  assign v_ev      = ev & oh[2];
  assign bad_ev    = ev & ~oh[2];
  assign ph0       = v_ev && (idx == 2'd0);
  assign commit    = (state_q == COMMIT);
  assign stall_hit = !v_ev && (scnt == SMAX - 1'b1);
  assign stall     = stall_r & ~v_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q    <= '0;
      h_prev <= '0;
      seg_q  <= '0;
      bs_q   <= 1'b0;
    end else begin
      h_q    <= H;
      h_prev <= h_q;
      seg_q  <= {segB, segA};
      bs_q   <= Bs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt    <= '0;
      stall_r <= 1'b0;
    end else if (v_ev) begin
      scnt    <= '0;
      stall_r <= 1'b0;
    end else begin
      if (scnt != SMAX)
        scnt <= scnt + 1'b1;
      if (stall_hit)
        stall_r <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEEK;
      nxt        <= 2'd0;
      work       <= '0;
      bs_acc     <= 1'b0;
      bs_last    <= 1'b0;
      pending    <= 1'b0;
      disp       <= '0;
      bs_out     <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      rd_data    <= 1'b0;
    end else begin
      sync_err   <= bad_ev;
      frame_done <= 1'b0;
      rd_data    <= disp[rd_addr];
      if (pending && !lock) begin
        disp       <= lit;
        bs_out     <= bs_last;
        frame_done <= 1'b1;
        pending    <= 1'b0;
      end
      if (commit) begin
        pending <= 1'b1;
        bs_last <= bs_acc;
      end
      if (stall_hit) begin
        state_q <= SEEK;
        work    <= '0;
        bs_acc  <= 1'b0;
      end else begin
        case (state_q)
          SEEK: begin
            if (ph0) begin
              work[31:0] <= seg_q;
              bs_acc     <= bs_q;
              nxt        <= 2'd1;
              state_q    <= RUN;
            end
          end
          RUN: begin
            if (bad_ev) begin
              state_q <= SEEK;
              work    <= '0;
              bs_acc  <= 1'b0;
            end else if (v_ev && idx == nxt) begin
              work[{idx, 5'd0} +: 32] <= seg_q;
              bs_acc <= bs_acc | bs_q;
              if (idx == 2'd3)
                state_q <= COMMIT;
              else
                nxt <= nxt + 1'b1;
            end else if (v_ev) begin
              sync_err <= 1'b1;
              // an early phase 0 restarts the frame instead of resyncing
              if (idx == 2'd0) begin
                work   <= {{(DISP_BITS-32){1'b0}}, seg_q};
                bs_acc <= bs_q;
                nxt    <= 2'd1;
              end else begin
                state_q <= SEEK;
                work    <= '0;
                bs_acc  <= 1'b0;
              end
            end
          end
          COMMIT: begin
            work    <= '0;
            bs_acc  <= 1'b0;
            state_q <= SEEK;
            if (ph0) begin
              work    <= {{(DISP_BITS-32){1'b0}}, seg_q};
              bs_acc  <= bs_q;
              nxt     <= 2'd1;
              state_q <= RUN;
            end
          end
          default: state_q <= SEEK;
        endcase
      end
    end
  end

  gnw_lcd_persist #(
    .PERSIST (PERSIST)
  ) u_persist (
    .clk    (clk),
    .rst    (rst),
    .commit (commit),
    .seen   (work),
    .lit    (lit)
  );

endmodule
